// File: rtl/prog_loader_8to16.sv
// Boot-time loader: packs a big-endian byte stream into 16-bit words for the program RAM.
// Optional checksum trailer after the halt word is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader_8to16 #(
    parameter int          ADDR_W    = 10,
    parameter int          DEPTH     = 1024,
    parameter logic [15:0] HALT_WORD = 16'h3c00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_din,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              overrun,
    output logic              cksum_err,
    output logic              proc_start
);

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, LOAD_HI, LOAD_LO, WRITE, DONE, CHK_HI, CHK_LO
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, LOAD_HI, LOAD_LO, WRITE, DONE
    } state_t;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   WC_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [7:0]          hi_q, hi_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic [15:0]         ram_din_q, ram_din_d;
    logic                ram_write_en_q, ram_write_en_d;
    logic                byte_ready_q, byte_ready_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic                proc_start_q, proc_start_d;
    logic                accept;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [15:0]         sum_q, sum_d;
    logic                cksum_err_q, cksum_err_d;
`endif

    assign accept = byte_valid && byte_ready_q;

    always_comb begin
        state_d        = state_q;
        hi_d           = hi_q;
        addr_d         = addr_q;
        word_count_d   = word_count_q;
        ram_din_d      = ram_din_q;
        ram_write_en_d = 1'b0;
        done_d         = done_q;
        overrun_d      = overrun_q;
        proc_start_d   = proc_start_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d          = sum_q;
        cksum_err_d    = cksum_err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (load_req) begin
                    state_d      = LOAD_HI;
                    addr_d       = '0;
                    word_count_d = '0;
                    done_d       = 1'b0;
                    overrun_d    = 1'b0;
                    proc_start_d = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d        = '0;
                    cksum_err_d  = 1'b0;
`endif
                end
            end
            LOAD_HI: begin
                if (accept) begin
                    hi_d    = byte_in;
                    state_d = LOAD_LO;
                end
            end
            LOAD_LO: begin
                if (accept) begin
                    ram_din_d      = {hi_q, byte_in};
                    ram_write_en_d = 1'b1;
                    state_d        = WRITE;
                end
            end
            WRITE: begin
                word_count_d = word_count_q + WC_ONE;
`ifdef PROG_LOADER_CHECKSUM_EN
                sum_d        = sum_q + ram_din_q;
`endif
                if (ram_din_q == HALT_WORD) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d      = CHK_HI;
`else
                    state_d      = DONE;
                    done_d       = 1'b1;
                    proc_start_d = 1'b1;
`endif
                end else if (addr_q == LAST_ADDR) begin
                    // The last RAM word is never followed by a wrap to address 0.
                    state_d   = DONE;
                    done_d    = 1'b1;
                    overrun_d = 1'b1;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = LOAD_HI;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK_HI: begin
                if (accept) begin
                    hi_d    = byte_in;
                    state_d = CHK_LO;
                end
            end
            CHK_LO: begin
                if (accept) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    if ({hi_q, byte_in} == sum_q) begin
                        proc_start_d = 1'b1;
                    end else begin
                        cksum_err_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
`ifdef PROG_LOADER_CHECKSUM_EN
        byte_ready_d = (state_d == LOAD_HI) || (state_d == LOAD_LO) ||
                       (state_d == CHK_HI)  || (state_d == CHK_LO);
`else
        byte_ready_d = (state_d == LOAD_HI) || (state_d == LOAD_LO);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            hi_q           <= '0;
            addr_q         <= '0;
            word_count_q   <= '0;
            ram_din_q      <= '0;
            ram_write_en_q <= 1'b0;
            byte_ready_q   <= 1'b0;
            done_q         <= 1'b0;
            overrun_q      <= 1'b0;
            proc_start_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q          <= '0;
            cksum_err_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            hi_q           <= hi_d;
            addr_q         <= addr_d;
            word_count_q   <= word_count_d;
            ram_din_q      <= ram_din_d;
            ram_write_en_q <= ram_write_en_d;
            byte_ready_q   <= byte_ready_d;
            done_q         <= done_d;
            overrun_q      <= overrun_d;
            proc_start_q   <= proc_start_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q          <= sum_d;
            cksum_err_q    <= cksum_err_d;
`endif
        end
    end

    assign byte_ready   = byte_ready_q;
    assign ram_write_en = ram_write_en_q;
    assign ram_addr     = addr_q;
    assign ram_din      = ram_din_q;
    assign word_count   = word_count_q;
    assign done         = done_q;
    assign overrun      = overrun_q;
    assign proc_start   = proc_start_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign cksum_err    = cksum_err_q;
`else
    assign cksum_err    = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader_8to16.sv
// Scoreboard bench for prog_loader_8to16: expected RAM writes are queued by the stimulus
// and popped by a monitor that watches ram_write_en; status outputs are checked directly.
module tb_prog_loader_8to16;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_req = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              ram_write_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_din;
    logic [ADDR_W:0]   word_count;
    logic              done;
    logic              overrun;
    logic              cksum_err;
    logic              proc_start;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;
    wr_t expQ[$];

    prog_loader_8to16 #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .HALT_WORD(16'h3c00)) dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .ram_write_en(ram_write_en),
        .ram_addr(ram_addr), .ram_din(ram_din), .word_count(word_count), .done(done),
        .overrun(overrun), .cksum_err(cksum_err), .proc_start(proc_start)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ram_write_en === 1'b1) begin
            checkOutput("byte_ready low during WRITE", 32'(byte_ready), 32'h0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected RAM write addr", 32'(ram_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                checkOutput("RAM write addr", 32'(ram_addr), 32'(e.addr));
                checkOutput("RAM write data", 32'(ram_din), 32'(e.data));
            end
        end
    end

    task automatic sendByte(input logic [7:0] b, input bit gap);
        bit acc;
        acc = 1'b0;
        if (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
            @(posedge clk);
        end
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_in    = b;
            acc        = byte_ready;
            @(posedge clk);
        end
        #1 byte_valid = 1'b0;
        if (!acc) checkOutput("byte accept timeout", 32'h0, 32'h1);
    endtask

    task automatic applyStimulus(input logic [7:0] stream[$], input bit gap);
        foreach (stream[i]) sendByte(stream[i], gap);
    endtask

    task automatic sendChecksum(input logic [15:0] sum);
`ifdef PROG_LOADER_CHECKSUM_EN
        sendByte(sum[15:8], 1'b0);
        sendByte(sum[7:0], 1'b0);
`else
        if (sum == 16'h0) $display("[TB] checksum trailer not used");
`endif
    endtask

    task automatic pulseLoad();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done reached", 32'(done), 32'h1);
    endtask

    task automatic pushWrite(input int a, input logic [15:0] d);
        wr_t e;
        e.addr = ADDR_W'(a);
        e.data = d;
        expQ.push_back(e);
    endtask

    task automatic checkStatus(input string tag, input int wc, input bit ov, input bit ps, input bit ce);
        checkOutput({tag, " done"}, 32'(done), 32'h1);
        checkOutput({tag, " word_count"}, 32'(word_count), 32'(wc));
        checkOutput({tag, " overrun"}, 32'(overrun), 32'(ov));
        checkOutput({tag, " proc_start"}, 32'(proc_start), 32'(ps));
        checkOutput({tag, " cksum_err"}, 32'(cksum_err), 32'(ce));
        checkOutput({tag, " byte_ready"}, 32'(byte_ready), 32'h0);
        checkOutput({tag, " pending writes"}, 32'(expQ.size()), 32'h0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " byte_ready"}, 32'(byte_ready), 32'h0);
        checkOutput({tag, " ram_write_en"}, 32'(ram_write_en), 32'h0);
        checkOutput({tag, " done"}, 32'(done), 32'h0);
        checkOutput({tag, " overrun"}, 32'(overrun), 32'h0);
        checkOutput({tag, " cksum_err"}, 32'(cksum_err), 32'h0);
        checkOutput({tag, " proc_start"}, 32'(proc_start), 32'h0);
        checkOutput({tag, " ram_addr"}, 32'(ram_addr), 32'h0);
        checkOutput({tag, " ram_din"}, 32'(ram_din), 32'h0);
        checkOutput({tag, " word_count"}, 32'(word_count), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] s[$];

        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle byte_ready", 32'(byte_ready), 32'h0);

        // Basic three-word program ending in the halt word.
        $display("[TB] basic load");
        pulseLoad();
        pushWrite(0, 16'h1234);
        pushWrite(1, 16'hABCD);
        pushWrite(2, 16'h3C00);
        s = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h3C, 8'h00};
        applyStimulus(s, 1'b0);
        sendChecksum(16'hFA01);
        waitDone();
        checkStatus("basic", 3, 1'b0, 1'b1, 1'b0);

        // Restart from DONE with a gappy byte stream.
        $display("[TB] gappy load");
        pulseLoad();
        checkOutput("restart proc_start drop", 32'(proc_start), 32'h0);
        checkOutput("restart done drop", 32'(done), 32'h0);
        checkOutput("restart word_count", 32'(word_count), 32'h0);
        pushWrite(0, 16'h1234);
        pushWrite(1, 16'hABCD);
        pushWrite(2, 16'h3C00);
        applyStimulus(s, 1'b1);
        sendChecksum(16'hFA01);
        waitDone();
        checkStatus("gappy", 3, 1'b0, 1'b1, 1'b0);

        // Reset with a half word latched must discard it.
        $display("[TB] reset mid-load");
        pulseLoad();
        sendByte(8'h12, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        pulseLoad();
        pushWrite(0, 16'h3C00);
        s = '{8'h3C, 8'h00};
        applyStimulus(s, 1'b0);
        sendChecksum(16'h3C00);
        waitDone();
        checkStatus("after reset", 1, 1'b0, 1'b1, 1'b0);

        // Fill all DEPTH words without a halt.
        $display("[TB] overrun");
        pulseLoad();
        for (int i = 0; i < DEPTH; i++) pushWrite(i, 16'(i + 1));
        s = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04};
        applyStimulus(s, 1'b0);
        waitDone();
        checkStatus("overrun", 4, 1'b1, 1'b0, 1'b0);
        byte_valid = 1'b1;
        byte_in    = 8'h55;
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        checkOutput("overrun stays not ready", 32'(byte_ready), 32'h0);
        checkOutput("overrun ram_addr held", 32'(ram_addr), 32'h3);

        // Reload after an overrun.
        $display("[TB] reload after overrun");
        pulseLoad();
        checkOutput("reload overrun drop", 32'(overrun), 32'h0);
        checkOutput("reload ram_addr", 32'(ram_addr), 32'h0);
        pushWrite(0, 16'h3C00);
        s = '{8'h3C, 8'h00};
        applyStimulus(s, 1'b0);
        sendChecksum(16'h3C00);
        waitDone();
        checkStatus("reload", 1, 1'b0, 1'b1, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
        $display("[TB] checksum good");
        pulseLoad();
        pushWrite(0, 16'h0001);
        pushWrite(1, 16'h3C00);
        s = '{8'h00, 8'h01, 8'h3C, 8'h00};
        applyStimulus(s, 1'b0);
        sendChecksum(16'h3C01);
        waitDone();
        checkStatus("cksum good", 2, 1'b0, 1'b1, 1'b0);

        $display("[TB] checksum bad");
        pulseLoad();
        pushWrite(0, 16'h0001);
        pushWrite(1, 16'h3C00);
        applyStimulus(s, 1'b0);
        sendChecksum(16'h3C02);
        waitDone();
        checkStatus("cksum bad", 2, 1'b0, 1'b0, 1'b1);
`endif

        repeat (3) @(negedge clk);
        checkOutput("final pending writes", 32'(expQ.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
